mini_logic_arbiter: RTL and testbench
=====================================

Name: mini_logic_arbiter

Overview:
- Shares one registered WIDTH-bit bitwise logic unit (OR/AND/XOR/NOR) between 4 requesters.
- Each requester issues an operation with an opcode and two operands. The block grants the unit round-robin, computes the result and returns it with the requester ID over a valid/ready result port.
- Sits between the wire-tracing datapath engines and the shared mini-machine gate logic. It replaces the per-engine gate copies.

Parameters:
- WIDTH, 16, operand/result width in bits (legal range 1..64).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- req  input  4  per-requester request; bit i is requester i.
- op  input  8  opcodes, 2 bits per requester; op[2i+1:2i] belongs to requester i. 00=OR, 01=AND, 10=XOR, 11=NOR.
- a  input  4*WIDTH  operand A, requester i at a[WIDTH*i +: WIDTH].
- b  input  4*WIDTH  operand B, same packing.
- gnt  output  4  one-hot grant; combinational; at most one bit set.
- res_valid  output  1  result register holds an unconsumed result.
- res_id  output  2  index of requester owning res_data.
- res_data  output  WIDTH  computed result.
- res_ready  input  1  consumer accepts result when res_valid && res_ready.

Behaviour:
- Reset (async, rst=1): res_valid=0, res_id=0, res_data=0, ptr=0, state=EMPTY. gnt=0 while rst=1.
- State machine: EMPTY (no result held) and FULL (result held, res_valid=1).
- Capture condition: cap = (req!=0) && (state==EMPTY || res_ready). Otherwise gnt=0.
- Grant selection: round-robin search starting at index ptr, then ptr+1, ... mod 4. The first set req bit wins. gnt is one-hot of the winner while cap=1.
- Handshake: a requester holds req, op, a and b stable until it sees its gnt bit high. The operands are captured at the rising edge of the cycle in which gnt is high. The requester may drop req or present a new operation in the next cycle.
- On capture edge:
  - res_data <= f(op_w, a_w, b_w), where NOR = ~(a|b), truncated to WIDTH.
  - res_id <= winner.
  - res_valid <= 1.
  - ptr <= (winner+1) mod 4.
- Latency: result visible the cycle after the grant (1 cycle).
- Consume without new capture (FULL, res_ready=1, cap winner none): res_valid <= 0, state -> EMPTY. res_data and res_id hold their last values.
- Simultaneous consume and capture (FULL, res_ready=1, req!=0): the old result is consumed and the new result loads the same edge. res_valid stays 1. Throughput is 1 op/cycle.
- Backpressure: FULL with res_ready=0 means gnt=0 and all outputs hold stable regardless of req/op/a/b changes.
- ptr updates only on capture. An idle cycle does not move priority.
- Wrap-around: ptr=3 with winner 3 gives ptr=0. The search from ptr=2 checks order 2,3,0,1.
- Fairness: with all 4 requesting continuously and res_ready=1, the grants cycle 0,1,2,3,0,... Any requesting agent waits at most 3 captures.
- Reset mid-operation: an unconsumed result is discarded. A requester whose req was pending is not granted. After reset deasserts, arbitration restarts at ptr=0.
- Request changes in a cycle without grant have no effect on state.

Test Plan:
- Reset, then req=0001, op0=00, a0=16'h00F0, b0=16'h0F00, res_ready=1.
  - Required: gnt=0001 in the same cycle.
  - Next cycle: res_valid=1, res_id=0, res_data=16'h0FF0.
  - Following cycle (req=0): res_valid=0.
- Opcode sweep on requester 2 with a=16'hF0F0, b=16'hFF00:
  - op=00 (OR) -> 16'hFFF0.
  - op=01 (AND) -> 16'hF000.
  - op=10 (XOR) -> 16'h0FF0.
  - op=11 (NOR) -> 16'h000F.
  - All with res_id=2.
- req=1111 held, res_ready=1 for 8 cycles -> gnt sequence 0001,0010,0100,1000,0001,0010,0100,1000. res_valid stays 1 from cycle 2 onward. res_id follows 0,1,2,3 one cycle delayed.
- Backpressure: capture for requester 1, then res_ready=0 for 3 cycles with req=0101.
  - Required during stall: gnt=0000; res_id=1 and res_data unchanged.
  - On res_ready=1: gnt=0100, because ptr=2 after granting 1.
- Grant to requester 3 (ptr->0), then idle 2 cycles, then req=1010 -> gnt=0010. Confirms ptr wrap and no movement during idle.
- Assert rst for 1 cycle while FULL (res_valid=1, res_id=3) and req=0100 -> res_valid=0 and res_data=0 immediately, with no gnt during reset. After release with req=1001: gnt=0001.

Source files
------------

// File: rtl/mini_logic_arbiter.sv
// mini_logic_arbiter
//   Shares one registered WIDTH-bit bitwise logic unit (OR/AND/XOR/NOR)
//   between four requesters. Requests are granted round-robin. Each result
//   comes back one cycle after its grant, tagged with the requester index,
//   over a valid/ready result port.
//
//   state | meaning
//   ------+--------------------------------------------------------
//   EMPTY | result register holds nothing; any request may be captured
//   FULL  | result register holds an unconsumed result (res_valid=1)
//
// Ports:
//   clk        clock, rising edge
//   rst        asynchronous active-high reset
//   req[3:0]   per-requester request
//   op[7:0]    2-bit opcode per requester (00 OR, 01 AND, 10 XOR, 11 NOR)
//   a, b       4*WIDTH packed operands, requester i at [WIDTH*i +: WIDTH]
//   gnt[3:0]   combinational one-hot grant
//   res_valid  result register holds an unconsumed result
//   res_id     requester that owns res_data
//   res_data   computed result
//   res_ready  consumer accepts the result when res_valid && res_ready
module mini_logic_arbiter #(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [3:0]         req,
  input  logic [7:0]         op,
  input  logic [4*WIDTH-1:0] a,
  input  logic [4*WIDTH-1:0] b,
  output logic [3:0]         gnt,
  output logic               res_valid,
  output logic [1:0]         res_id,
  output logic [WIDTH-1:0]   res_data,
  input  logic               res_ready
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  localparam logic [1:0] OP_OR  = 2'b00;
  localparam logic [1:0] OP_AND = 2'b01;
  localparam logic [1:0] OP_XOR = 2'b10;
  localparam logic [1:0] OP_NOR = 2'b11;

  state_t             state_q;
  state_t             state_d;
  logic [1:0]         ptr_q;
  logic [1:0]         res_id_q;
  logic [WIDTH-1:0]   res_data_q;

  logic               cap;
  logic               found;
  logic [1:0]         win;
  logic [1:0]         idx;
  logic [1:0]         op_w;
  logic [WIDTH-1:0]   a_w;
  logic [WIDTH-1:0]   b_w;
  logic [WIDTH-1:0]   f_w;

  // Round-robin search starting at ptr_q; the first set request wins.
  always_comb begin
    found = 1'b0;
    win   = 2'd0;
    idx   = 2'd0;
    for (int k = 0; k < 4; k++) begin
      idx = ptr_q + 2'(k);
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  // The result slot is free when EMPTY, or when the held result is being
  // consumed this same cycle. rst gates the grant so nothing is handed out
  // while the block is held in reset.
  assign cap = found && !rst && (state_q == EMPTY || res_ready);

  always_comb begin
    gnt = 4'b0000;
    if (cap) begin
      gnt[win] = 1'b1;
    end
  end

  // Operand mux for the winning requester and the shared logic unit.
  always_comb begin
    op_w = op[2*win +: 2];
    a_w  = a[WIDTH*win +: WIDTH];
    b_w  = b[WIDTH*win +: WIDTH];
    f_w  = '0;
    case (op_w)
      OP_OR:   f_w = a_w | b_w;
      OP_AND:  f_w = a_w & b_w;
      OP_XOR:  f_w = a_w ^ b_w;
      OP_NOR:  f_w = ~(a_w | b_w);
      default: f_w = '0;
    endcase
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY: begin
        if (cap) begin
          state_d = FULL;
        end
      end
      FULL: begin
        if (cap) begin
          state_d = FULL;
        end else if (res_ready) begin
          state_d = EMPTY;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Result register and priority pointer only move on a capture; a plain
  // consume leaves res_id/res_data holding their last values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q      <= 2'd0;
      res_id_q   <= 2'd0;
      res_data_q <= '0;
    end else if (cap) begin
      ptr_q      <= win + 2'd1;
      res_id_q   <= win;
      res_data_q <= f_w;
    end
  end

  assign res_valid = (state_q == FULL);
  assign res_id    = res_id_q;
  assign res_data  = res_data_q;

endmodule

// File: tb/tb_mini_logic_arbiter.sv
// tb_mini_logic_arbiter
//   Directed-vector bench for mini_logic_arbiter (WIDTH=16). Inputs change
//   1 time unit after a rising edge; combinational gnt is sampled 1 unit
//   after that, registered outputs 1 unit after each edge.
module tb_mini_logic_arbiter;

  localparam int W = 16;

  logic           clk;
  logic           rst;
  logic [3:0]     req;
  logic [7:0]     op;
  logic [4*W-1:0] a;
  logic [4*W-1:0] b;
  logic [3:0]     gnt;
  logic           res_valid;
  logic [1:0]     res_id;
  logic [W-1:0]   res_data;
  logic           res_ready;

  int errors;
  int checks;

  mini_logic_arbiter #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .op        (op),
    .a         (a),
    .b         (b),
    .gnt       (gnt),
    .res_valid (res_valid),
    .res_id    (res_id),
    .res_data  (res_data),
    .res_ready (res_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_slot(input int i, input logic [1:0] o, input logic [W-1:0] av,
                          input logic [W-1:0] bv);
    op[2*i +: 2] = o;
    a[W*i +: W]  = av;
    b[W*i +: W]  = bv;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    #1;
  endtask

  logic [W-1:0] sweep_exp [4];

  initial begin
    errors    = 0;
    checks    = 0;
    rst       = 1'b1;
    req       = 4'b0000;
    op        = '0;
    a         = '0;
    b         = '0;
    res_ready = 1'b1;
    sweep_exp[0] = 16'hFFF0;
    sweep_exp[1] = 16'hF000;
    sweep_exp[2] = 16'h0FF0;
    sweep_exp[3] = 16'h000F;

    // Reset state, with a request pending to show gnt is blocked.
    req = 4'b0001;
    step();
    chk("rst_valid", 64'(res_valid), 64'd0);
    chk("rst_id",    64'(res_id),    64'd0);
    chk("rst_data",  64'(res_data),  64'd0);
    chk("rst_gnt",   64'(gnt),       64'd0);
    req = 4'b0000;
    step();
    rst = 1'b0;
    #1;

    // Single OR on requester 0.
    set_slot(0, 2'b00, 16'h00F0, 16'h0F00);
    req = 4'b0001;
    #1;
    chk("t1_gnt", 64'(gnt), 64'h1);
    step();
    req = 4'b0000;
    chk("t1_valid", 64'(res_valid), 64'd1);
    chk("t1_id",    64'(res_id),    64'd0);
    chk("t1_data",  64'(res_data),  64'h0FF0);
    step();
    chk("t1_drain", 64'(res_valid), 64'd0);
    chk("t1_hold",  64'(res_data),  64'h0FF0);

    // Opcode sweep on requester 2.
    for (int k = 0; k < 4; k++) begin
      set_slot(2, 2'(k), 16'hF0F0, 16'hFF00);
      req = 4'b0100;
      #1;
      chk("sw_gnt", 64'(gnt), 64'h4);
      step();
      req = 4'b0000;
      chk("sw_data", 64'(res_data), 64'(sweep_exp[k]));
      chk("sw_id",   64'(res_id),   64'd2);
      step();
    end

    // Fairness: all four requesting, ptr back at 0 after reset.
    do_reset();
    for (int i = 0; i < 4; i++) set_slot(i, 2'b00, 16'(16'h0100 + i), 16'h0000);
    req = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      #1;
      chk("rr_gnt", 64'(gnt), 64'(4'b0001 << (i % 4)));
      step();
      chk("rr_valid", 64'(res_valid), 64'd1);
      chk("rr_id",    64'(res_id),    64'(i % 4));
      chk("rr_data",  64'(res_data),  64'(16'h0100 + (i % 4)));
    end
    req = 4'b0000;
    step();
    chk("rr_drain", 64'(res_valid), 64'd0);

    // Backpressure: ptr=0, capture requester 1, then stall.
    set_slot(1, 2'b00, 16'h1234, 16'h0000);
    req = 4'b0010;
    #1;
    chk("bp_gnt1", 64'(gnt), 64'h2);
    step();
    chk("bp_id1", 64'(res_id), 64'd1);
    res_ready = 1'b0;
    req = 4'b0101;
    for (int i = 0; i < 3; i++) begin
      set_slot(0, 2'(i), 16'(16'hAAAA + i), 16'h5555);
      set_slot(2, 2'(i), 16'h00FF, 16'(16'h0F0F + i));
      #1;
      chk("bp_gnt_stall", 64'(gnt), 64'h0);
      step();
      chk("bp_valid", 64'(res_valid), 64'd1);
      chk("bp_id",    64'(res_id),    64'd1);
      chk("bp_data",  64'(res_data),  64'h1234);
    end
    set_slot(2, 2'b10, 16'h00FF, 16'h0F0F);
    res_ready = 1'b1;
    #1;
    chk("bp_gnt_release", 64'(gnt), 64'h4);
    step();
    req = 4'b0000;
    chk("bp_id2",   64'(res_id),   64'd2);
    chk("bp_data2", 64'(res_data), 64'h0FF0);
    step();

    // Wrap: ptr=3, grant 3 -> ptr 0, idle, then req=1010 -> requester 1.
    set_slot(3, 2'b01, 16'hFFFF, 16'h00C3);
    req = 4'b1000;
    #1;
    chk("wr_gnt3", 64'(gnt), 64'h8);
    step();
    req = 4'b0000;
    chk("wr_data3", 64'(res_data), 64'h00C3);
    step();
    step();
    req = 4'b1010;
    #1;
    chk("wr_gnt", 64'(gnt), 64'h2);
    step();

    // Reset while FULL holding requester 3's result.
    req = 4'b1000;
    #1;
    chk("rm_gnt3", 64'(gnt), 64'h8);
    step();
    res_ready = 1'b0;
    req = 4'b0100;
    chk("rm_valid", 64'(res_valid), 64'd1);
    chk("rm_id",    64'(res_id),    64'd3);
    res_ready = 1'b1;
    rst = 1'b1;
    #1;
    chk("rm_rvalid", 64'(res_valid), 64'd0);
    chk("rm_rdata",  64'(res_data),  64'd0);
    chk("rm_rgnt",   64'(gnt),       64'd0);
    step();
    chk("rm_rgnt2", 64'(gnt), 64'd0);
    rst = 1'b0;
    req = 4'b1001;
    #1;
    chk("rm_gnt_after", 64'(gnt), 64'h1);
    step();
    req = 4'b0000;
    chk("rm_id_after", 64'(res_id), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
